// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - decode-stage scoreboard, redirect flush and ECALL sequencing controller
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [6:0]  d_opcode,
    input  logic [4:0]  d_rd,
    input  logic [4:0]  d_rs1,
    input  logic [4:0]  d_rs2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        ex_redirect,
    input  logic        ecall_done,
    output logic        f_stall,
    output logic        d_stall,
    output logic        d_flush,
    output logic        d_issue,
    output logic        ecall_go,
    output logic [31:0] busy_vec
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CALL  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [31:0]      busy_q;
    logic [31:0]      busy_nxt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] flush_cnt_nxt;

    logic use_rs1;
    logic use_rs2;
    logic writer_op;
    logic is_writer;
    logic is_ecall;
    logic hazard;
    logic flushing;
    logic enter_drain;
    logic call_exit;
    logic go_int;
    logic stall_int;
    logic issue_int;

    // Classify the decoded opcode: which sources it reads, whether it writes rd, and ECALL.
    always_comb begin
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writer_op = 1'b0;
        is_ecall  = 1'b0;
        case (d_opcode)
            OPC_OP: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                writer_op = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_IMM: begin
                use_rs1   = 1'b1;
                writer_op = 1'b1;
            end
            OPC_SYSTEM: begin
                use_rs1  = 1'b1;
                is_ecall = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                writer_op = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
            end
        endcase
    end

    // Writes to x0 are discarded, so they never occupy a scoreboard slot.
    assign is_writer = writer_op & (d_rd != 5'd0);

    // RAW on any used source or WAW on rd, judged against the registered scoreboard only.
    assign hazard = d_valid & ((use_rs1 & busy_q[d_rs1]) |
                               (use_rs2 & busy_q[d_rs2]) |
                               (is_writer & busy_q[d_rd]));

    assign flushing = ex_redirect | (flush_cnt != '0);

    // ECALL sequencing: wait for in-flight writes to retire, hand off, then retire the ECALL.
    always_comb begin
        state_nxt   = state;
        enter_drain = 1'b0;
        go_int      = 1'b0;
        call_exit   = 1'b0;
        case (state)
            IDLE: begin
                if (d_valid & is_ecall & !flushing & !hazard) begin
                    enter_drain = 1'b1;
                    state_nxt   = DRAIN;
                end
            end
            DRAIN: begin
                if (ex_redirect) begin
                    state_nxt = IDLE;
                end else if (busy_q == 32'd0) begin
                    go_int    = 1'b1;
                    state_nxt = CALL;
                end
            end
            CALL: begin
                if (ex_redirect) begin
                    state_nxt = IDLE;
                end else if (ecall_done) begin
                    call_exit = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A flush overrides any stall; the ECALL exit cycle releases the stall so it can retire.
    assign stall_int = !flushing & (hazard | (state != IDLE) | enter_drain) & !call_exit;
    assign issue_int = (d_valid & !flushing & !stall_int) | call_exit;

    // Next scoreboard: retire the writeback, then mark the issuing writer (set wins on a clash).
    always_comb begin
        busy_nxt = busy_q;
        if (wb_valid) begin
            busy_nxt[wb_rd] = 1'b0;
        end
        if (issue_int & is_writer) begin
            busy_nxt[d_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    // Next flush count: a redirect (re)loads the full window, otherwise count down to zero.
    always_comb begin
        flush_cnt_nxt = flush_cnt;
        if (ex_redirect) begin
            flush_cnt_nxt = CNT_W'(FLUSH_CYCLES);
        end else if (flush_cnt != '0) begin
            flush_cnt_nxt = flush_cnt - CNT_W'(1);
        end
    end

    // State registers, all cleared asynchronously so a reset aborts any flush or ECALL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy_q    <= 32'd0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            busy_q    <= busy_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // Outputs are forced low while reset is held, independent of the live decode inputs.
    assign d_flush  = !reset & flushing;
    assign d_stall  = !reset & stall_int;
    assign f_stall  = !reset & stall_int;
    assign d_issue  = !reset & issue_int;
    assign ecall_go = !reset & go_int;
    assign busy_vec = busy_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a rule-level model
module tb_hazard_ctrl;

    localparam int FLUSH = 2;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] IMM   = 7'b0010011;
    localparam logic [6:0] OPR   = 7'b0110011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] LUI   = 7'b0110111;
    localparam logic [6:0] SYS   = 7'b1110011;

    logic        clock = 1'b0;
    logic        reset;
    logic        d_valid;
    logic [6:0]  d_opcode;
    logic [4:0]  d_rd;
    logic [4:0]  d_rs1;
    logic [4:0]  d_rs2;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        ex_redirect;
    logic        ecall_done;
    logic        f_stall;
    logic        d_stall;
    logic        d_flush;
    logic        d_issue;
    logic        ecall_go;
    logic [31:0] busy_vec;

    int errors = 0;
    int checks = 0;

    // Model state: set of pending registers, remaining flush cycles, ECALL progress flags.
    bit [31:0] m_busy;
    int        m_flush_left;
    bit        m_draining;
    bit        m_calling;

    hazard_ctrl #(.FLUSH_CYCLES(FLUSH), .CNT_W(2)) dut (
        .clock       (clock),
        .reset       (reset),
        .d_valid     (d_valid),
        .d_opcode    (d_opcode),
        .d_rd        (d_rd),
        .d_rs1       (d_rs1),
        .d_rs2       (d_rs2),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .ex_redirect (ex_redirect),
        .ecall_done  (ecall_done),
        .f_stall     (f_stall),
        .d_stall     (d_stall),
        .d_flush     (d_flush),
        .d_issue     (d_issue),
        .ecall_go    (ecall_go),
        .busy_vec    (busy_vec)
    );

    always #5 clock = ~clock;

    function automatic int nsrc(input logic [6:0] o);
        case (o)
            7'b0110011, 7'b0100011, 7'b1100011: return 2;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic bit writes_rd(input logic [6:0] o, input logic [4:0] rd);
        case (o)
            7'b0110011, 7'b0000011, 7'b0010011, 7'b0110111,
            7'b0010111, 7'b1101111, 7'b1100111: return rd != 5'd0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy       = '0;
        m_flush_left = 0;
        m_draining   = 1'b0;
        m_calling    = 1'b0;
    endtask

    // One clock: compare every output against the model mid-cycle, then advance the model.
    task automatic tick();
        bit haz, flush, go, fin, start, stall, issue;
        int n;
        @(negedge clock);
        n   = nsrc(d_opcode);
        haz = 1'b0;
        if (d_valid) begin
            if (n >= 1 && m_busy[d_rs1]) haz = 1'b1;
            if (n == 2 && m_busy[d_rs2]) haz = 1'b1;
            if (writes_rd(d_opcode, d_rd) && m_busy[d_rd]) haz = 1'b1;
        end
        flush = ex_redirect || (m_flush_left > 0);
        go    = m_draining && (m_busy == 0) && !ex_redirect;
        fin   = m_calling && ecall_done && !ex_redirect;
        start = !m_draining && !m_calling && d_valid && (d_opcode == SYS) && !flush && !haz;
        stall = !flush && (haz || m_draining || m_calling || start) && !fin;
        issue = (d_valid && !flush && !stall) || fin;
        chk("m_d_flush", {31'd0, d_flush}, {31'd0, flush});
        chk("m_d_stall", {31'd0, d_stall}, {31'd0, stall});
        chk("m_f_stall", {31'd0, f_stall}, {31'd0, stall});
        chk("m_d_issue", {31'd0, d_issue}, {31'd0, issue});
        chk("m_ecall_go", {31'd0, ecall_go}, {31'd0, go});
        chk("m_busy_vec", busy_vec, m_busy);
        @(posedge clock);
        if (wb_valid) m_busy[wb_rd] = 1'b0;
        if (issue && writes_rd(d_opcode, d_rd)) m_busy[d_rd] = 1'b1;
        if (ex_redirect) m_flush_left = FLUSH;
        else if (m_flush_left > 0) m_flush_left--;
        if (m_draining) m_draining = !ex_redirect && !go;
        else m_draining = start;
        if (m_calling) m_calling = !ex_redirect && !ecall_done;
        else m_calling = go;
        #1;
    endtask

    task automatic instr(input logic v, input logic [6:0] o, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2);
        d_valid  = v;
        d_opcode = o;
        d_rd     = rd;
        d_rs1    = rs1;
        d_rs2    = rs2;
    endtask

    task automatic wb(input logic v, input logic [4:0] rd);
        wb_valid = v;
        wb_rd    = rd;
    endtask

    initial begin
        reset = 1'b1;
        instr(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        wb(1'b0, 5'd0);
        ex_redirect = 1'b0;
        ecall_done  = 1'b0;
        model_reset();
        #1;
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_issue", {31'd0, d_issue}, 32'h0);
        ex_redirect = 1'b1;
        instr(1'b1, OPR, 5'd3, 5'd1, 5'd2);
        #1;
        chk("rst_flush_over_redirect", {31'd0, d_flush}, 32'h0);
        chk("rst_issue_masked", {31'd0, d_issue}, 32'h0);
        ex_redirect = 1'b0;
        instr(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // lw x5 then add x6,x5,x1: stall until the cycle after x5 writes back
        instr(1'b1, LOAD, 5'd5, 5'd1, 5'd0);
        tick();
        chk("lw_busy", busy_vec, 32'h0000_0020);
        instr(1'b1, OPR, 5'd6, 5'd5, 5'd1);
        #1;
        chk("raw_d_stall", {31'd0, d_stall}, 32'h1);
        chk("raw_f_stall", {31'd0, f_stall}, 32'h1);
        tick();
        tick();
        wb(1'b1, 5'd5);
        #1;
        chk("raw_no_bypass", {31'd0, d_stall}, 32'h1);
        tick();
        wb(1'b0, 5'd0);
        #1;
        chk("raw_release", {31'd0, d_issue}, 32'h1);
        tick();
        chk("add_busy", busy_vec, 32'h0000_0040);
        instr(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        wb(1'b1, 5'd6);
        tick();
        wb(1'b0, 5'd0);

        // x0 destinations/sources never stall and never mark bit 0
        instr(1'b1, OPR, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        chk("x0_busy", busy_vec, 32'h0);
        instr(1'b1, LUI, 5'd7, 5'd7, 5'd7);
        tick();
        instr(1'b1, STORE, 5'd0, 5'd2, 5'd7);
        tick();
        tick();
        instr(1'b1, IMM, 5'd3, 5'd0, 5'd7);
        tick();
        instr(1'b1, LUI, 5'd7, 5'd0, 5'd0);
        tick();
        instr(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        wb(1'b1, 5'd7);
        tick();
        wb(1'b1, 5'd3);
        tick();
        wb(1'b0, 5'd0);
        chk("x7_x3_retired", busy_vec, 32'h0);

        // single redirect: flush for the redirect cycle plus two
        instr(1'b1, OPR, 5'd0, 5'd1, 5'd2);
        ex_redirect = 1'b1;
        #1;
        chk("redir_flush", {31'd0, d_flush}, 32'h1);
        chk("redir_no_issue", {31'd0, d_issue}, 32'h0);
        tick();
        ex_redirect = 1'b0;
        tick();
        tick();
        chk("redir_flush_end", {31'd0, d_flush}, 32'h0);
        chk("redir_issue_after", {31'd0, d_issue}, 32'h1);
        tick();

        // back-to-back redirects: window extends two cycles past the second
        ex_redirect = 1'b1;
        tick();
        tick();
        ex_redirect = 1'b0;
        tick();
        #1;
        chk("redir2_still", {31'd0, d_flush}, 32'h1);
        tick();
        chk("redir2_end", {31'd0, d_flush}, 32'h0);
        tick();

        // async reset in the middle of a flush with x5 pending
        instr(1'b1, LOAD, 5'd5, 5'd0, 5'd0);
        tick();
        instr(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        ex_redirect = 1'b1;
        tick();
        ex_redirect = 1'b0;
        instr(1'b1, OPR, 5'd6, 5'd5, 5'd1);
        #1;
        chk("pre_rst_busy", busy_vec, 32'h0000_0020);
        chk("pre_rst_flush", {31'd0, d_flush}, 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy_vec, 32'h0);
        chk("mid_rst_flush", {31'd0, d_flush}, 32'h0);
        chk("mid_rst_stall", {d_stall, f_stall, d_issue, ecall_go}, 32'h0);
        @(posedge clock);
        #1;
        instr(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        reset = 1'b0;
        model_reset();
        tick();

        // ECALL with x8 pending: drain, hand off, wait four cycles, retire
        instr(1'b1, LOAD, 5'd8, 5'd0, 5'd0);
        tick();
        chk("ecall_busy", busy_vec, 32'h0000_0100);
        instr(1'b1, SYS, 5'd0, 5'd0, 5'd0);
        #1;
        chk("ecall_enter_stall", {31'd0, d_stall}, 32'h1);
        tick();
        tick();
        tick();
        wb(1'b1, 5'd8);
        tick();
        wb(1'b0, 5'd0);
        #1;
        chk("ecall_go_pulse", {31'd0, ecall_go}, 32'h1);
        tick();
        for (int i = 0; i < 4; i++) tick();
        ecall_done = 1'b1;
        #1;
        chk("ecall_retire", {31'd0, d_issue}, 32'h1);
        chk("ecall_retire_nostall", {31'd0, d_stall}, 32'h0);
        tick();
        ecall_done = 1'b0;
        instr(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        tick();

        // redirect during DRAIN abandons the ECALL
        instr(1'b1, LOAD, 5'd8, 5'd0, 5'd0);
        tick();
        instr(1'b1, SYS, 5'd0, 5'd0, 5'd0);
        tick();
        tick();
        ex_redirect = 1'b1;
        #1;
        chk("drain_redir_flush", {31'd0, d_flush}, 32'h1);
        chk("drain_redir_go", {31'd0, ecall_go}, 32'h0);
        tick();
        ex_redirect = 1'b0;
        instr(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        wb(1'b1, 5'd8);
        tick();
        wb(1'b0, 5'd0);
        for (int i = 0; i < 4; i++) tick();
        chk("drain_redir_no_go", {31'd0, ecall_go}, 32'h0);

        // forced same-register writeback and issue: the set wins
        instr(1'b1, IMM, 5'd10, 5'd0, 5'd0);
        wb(1'b1, 5'd10);
        tick();
        wb(1'b0, 5'd0);
        instr(1'b0, 7'd0, 5'd0, 5'd0, 5'd0);
        chk("set_wins", busy_vec, 32'h0000_0400);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Sequencing controller for the decode stage.
- Keeps a register scoreboard of in-flight writes and stalls fetch/decode on RAW/WAW hazards.
- Flushes decode for a programmable number of cycles after an execute-stage redirect (taken branch, jal, jalr).
- Serialises ECALL by draining the pipeline before handing off to the environment.
- Sits between decode outputs and the fetch/decode pipeline registers.

Parameters:
- FLUSH_CYCLES, 2, number of cycles d_flush stays high after a redirect (1..2**CNT_W-1).
- CNT_W, 2, width of the flush counter.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- d_valid  input  1  decode holds a valid instruction.
- d_opcode  input  7  decoded opcode.
- d_rd  input  5  decoded destination register.
- d_rs1  input  5  decoded source 1.
- d_rs2  input  5  decoded source 2.
- wb_valid  input  1  writeback retires a register write this cycle.
- wb_rd  input  5  register being written back.
- ex_redirect  input  1  execute stage changes control flow this cycle.
- ecall_done  input  1  environment finished servicing the ECALL.
- f_stall  output  1  hold the fetch PC/instruction register.
- d_stall  output  1  hold the decode register.
- d_flush  output  1  bubble the decode register.
- d_issue  output  1  decode instruction advances to execute this cycle.
- ecall_go  output  1  one-cycle pulse requesting ECALL service.
- busy_vec  output  32  scoreboard; bit n set = write to xn pending.

Behaviour:
- Reset (async, any time, including mid-flush or mid-ECALL):
  - busy_vec=0, flush counter=0, FSM=IDLE.
  - All outputs 0.
- Source usage by opcode:
  - 0110011, 0100011, 1100011: rs1 and rs2.
  - 1100111, 0000011, 0010011, 1110011: rs1 only.
  - 0110111, 0010111, 1101111: no sources.
- Destination writers: 0110011, 0000011, 0010011, 0110111, 0010111, 1101111, 1100111 with d_rd!=0.
- x0 is never busy; bit 0 of busy_vec is tied 0.
- hazard = d_valid & (any used source busy | writer & busy[d_rd]).
  - Uses registered busy_vec only; no same-cycle writeback bypass.
- Scoreboard update at clock edge:
  - wb_valid clears busy[wb_rd].
  - d_issue of a writer sets busy[d_rd].
  - Both in the same cycle on the same register cannot occur (WAW stall guarantees this); if the bench forces it, set wins.
- Flush counter:
  - ex_redirect loads FLUSH_CYCLES. A redirect while counting reloads it.
  - Otherwise the counter decrements to 0.
  - d_flush = ex_redirect | (counter != 0), combinational.
- FSM states: IDLE, DRAIN, CALL.
  - IDLE -> DRAIN: d_valid & opcode 1110011 & !d_flush & no hazard.
  - DRAIN -> CALL: busy_vec==0. ecall_go pulses high for exactly the transition cycle.
  - CALL -> IDLE: ecall_done. d_issue=1 in that cycle (ECALL retires).
  - ex_redirect in DRAIN or CALL returns the FSM to IDLE with no ecall_go or issue.
- Output equations:
  - d_stall = !d_flush & (hazard | FSM!=IDLE | entering DRAIN) & !(CALL & ecall_done).
  - f_stall = d_stall.
  - d_issue = d_valid & !d_flush & !d_stall, or the CALL exit cycle.
  - d_issue is never high in the same cycle as d_flush.
- Priority: reset > ex_redirect/flush > ECALL FSM > hazard stall.
- Latency:
  - A hazard resolves the cycle after the matching wb_valid.
  - ecall_go fires the cycle after busy_vec reaches 0.

Test Plan:
- Reset while busy_vec=0x0000_0020 and counter=2 -> all outputs 0, busy_vec=0 immediately, without waiting for a clock.
- Issue lw x5 (0000011, rd=5), then add x6,x5,x1 -> busy_vec bit5=1. add is held with d_stall=f_stall=1 until the cycle after wb_valid & wb_rd=5, then d_issue=1 and busy bit6 set.
- Instruction with rd=0, or sources x0 -> never stalls; busy_vec bit0 stays 0.
- ex_redirect for one cycle with FLUSH_CYCLES=2 -> d_flush high 3 cycles (redirect cycle + 2) with d_issue=0. A second redirect in the second cycle extends d_flush to end 2 cycles after it.
- ECALL with busy_vec=0x0000_0100:
  - d_stall=1 through DRAIN.
  - After wb_rd=8 clears the bit, ecall_go=1 for one cycle.
  - With ecall_done held low 4 cycles, stall persists; when ecall_done=1, d_issue=1 and FSM returns to IDLE.
- ex_redirect during DRAIN -> FSM back to IDLE, ecall_go never asserts, d_flush asserted.
